// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register file.
package i2c_pkg;

   localparam int   BYTE_W = 8;
   localparam logic ACK    = 1'b0;
   localparam logic NACK   = 1'b1;

   typedef enum logic [3:0] {
      IDLE,
      DEV_ADDR,
      DEV_ACK,
      REG_PTR,
      PTR_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RD_ACK,
      IGNORE
   } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings raw SCL/SDA into the system clock domain and flags SCL edges
// plus START/STOP conditions from the last two synchronized samples.
module i2c_bus_sync (
   input  logic clk,
   input  logic rst,
   input  logic scl_in,
   input  logic sda_in,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop,
   output logic sda_s
);

   // [0] metastability stage, [1] synchronized sample, [2] history
   logic [2:0] scl_q;
   logic [2:0] sda_q;

   // Reset to the idle-bus level so leaving reset never fakes an edge on SDA.
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_q <= 3'b111;
         sda_q <= 3'b111;
      end else begin
         scl_q <= {scl_q[1:0], scl_in};
         sda_q <= {sda_q[1:0], sda_in};
      end
   end

   assign scl_rise = scl_q[1] & ~scl_q[2];
   assign scl_fall = ~scl_q[1] & scl_q[2];
   assign start    = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
   assign stop     = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
   assign sda_s    = sda_q[1];

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target exposing a byte-wide register file with auto-incrementing
// pointer; completed writes are reported locally as a one-cycle strobe.
module i2c_target_regfile
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = 7'h39,
   parameter int         REG_ADDR_W = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  SCL_IN,
   input  logic                  SDA_IN,
   output logic                  SDA_OE,
   output logic                  WR_STROBE,
   output logic [REG_ADDR_W-1:0] WR_ADDR,
   output logic [BYTE_W-1:0]     WR_DATA,
   input  logic [REG_ADDR_W-1:0] RD_ADDR,
   output logic [BYTE_W-1:0]     RD_DATA,
   output logic                  BUSY
);

   localparam logic [3:0] BIT_LAST = 4'(BYTE_W);

   logic scl_rise, scl_fall, start, stop, sda_s;

   state_t                  state;
   logic [BYTE_W-1:0]       shreg;
   logic [3:0]              bit_cnt;
   logic [REG_ADDR_W-1:0]   ptr;
   logic                    rw;
   logic                    master_ack;
   logic [BYTE_W-1:0]       regs [2**REG_ADDR_W];

   i2c_bus_sync u_bus_sync (
      .clk      (CLK),
      .rst      (RST),
      .scl_in   (SCL_IN),
      .sda_in   (SDA_IN),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .start    (start),
      .stop     (stop),
      .sda_s    (sda_s)
   );

   assign RD_DATA = regs[RD_ADDR];

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         shreg      <= '0;
         bit_cnt    <= '0;
         ptr        <= '0;
         rw         <= 1'b0;
         master_ack <= NACK;
         SDA_OE     <= 1'b0;
         WR_STROBE  <= 1'b0;
         WR_ADDR    <= '0;
         WR_DATA    <= '0;
         BUSY       <= 1'b0;
         // NOTE: the register file must read 0x00 after reset, so it is a
         // flop array cleared here rather than an uninitialised RAM macro.
         for (int i = 0; i < 2**REG_ADDR_W; i++) regs[i] <= '0;
      end else begin
         WR_STROBE <= 1'b0;
         if (start) begin
            state   <= DEV_ADDR;
            bit_cnt <= '0;
            SDA_OE  <= 1'b0;
         end else if (stop) begin
            state  <= IDLE;
            SDA_OE <= 1'b0;
            BUSY   <= 1'b0;
         end else begin
            unique case (state)
               IDLE, IGNORE: ;
               DEV_ADDR: begin
                  if (scl_rise) begin
                     shreg   <= {shreg[BYTE_W-2:0], sda_s};
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall && bit_cnt == BIT_LAST) begin
                     if (shreg[BYTE_W-1:1] == SLAVE_ADDR) begin
                        rw     <= shreg[0];
                        BUSY   <= 1'b1;
                        SDA_OE <= 1'b1;
                        state  <= DEV_ACK;
                     end else begin
                        state <= IGNORE;
                     end
                  end
               end
               DEV_ACK: begin
                  if (scl_fall) begin
                     if (rw) begin
                        shreg   <= regs[ptr];
                        SDA_OE  <= ~regs[ptr][BYTE_W-1];
                        bit_cnt <= 4'd1;
                        state   <= RDATA;
                     end else begin
                        SDA_OE  <= 1'b0;
                        bit_cnt <= '0;
                        state   <= REG_PTR;
                     end
                  end
               end
               REG_PTR: begin
                  if (scl_rise) begin
                     shreg   <= {shreg[BYTE_W-2:0], sda_s};
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall && bit_cnt == BIT_LAST) begin
                     ptr    <= shreg[REG_ADDR_W-1:0];
                     SDA_OE <= 1'b1;
                     state  <= PTR_ACK;
                  end
               end
               PTR_ACK, WDATA_ACK: begin
                  if (scl_fall) begin
                     SDA_OE  <= 1'b0;
                     bit_cnt <= '0;
                     state   <= WDATA;
                  end
               end
               WDATA: begin
                  if (scl_rise) begin
                     shreg   <= {shreg[BYTE_W-2:0], sda_s};
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall && bit_cnt == BIT_LAST) begin
                     regs[ptr] <= shreg;
                     WR_ADDR   <= ptr;
                     WR_DATA   <= shreg;
                     WR_STROBE <= 1'b1;
                     SDA_OE    <= 1'b1;
                     ptr       <= ptr + 1'b1;
                     state     <= WDATA_ACK;
                  end
               end
               RDATA: begin
                  // shreg[MSB] is the bit currently on the wire
                  if (scl_fall) begin
                     if (bit_cnt == BIT_LAST) begin
                        SDA_OE <= 1'b0;
                        ptr    <= ptr + 1'b1;
                        state  <= RD_ACK;
                     end else begin
                        SDA_OE  <= ~shreg[BYTE_W-2];
                        shreg   <= {shreg[BYTE_W-2:0], 1'b0};
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end
               end
               RD_ACK: begin
                  if (scl_rise) begin
                     master_ack <= sda_s;
                  end else if (scl_fall) begin
                     if (master_ack == ACK) begin
                        shreg   <= regs[ptr];
                        SDA_OE  <= ~regs[ptr][BYTE_W-1];
                        bit_cnt <= 4'd1;
                        state   <= RDATA;
                     end else begin
                        state <= IGNORE;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed plus randomized I2C transactions against a behavioural memory model.
module tb_i2c_target_regfile;

   localparam int Q = 8;   // CLK cycles per quarter SCL period

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       SCL_IN, SDA_IN;
   logic       SDA_OE, WR_STROBE, BUSY;
   logic [7:0] WR_ADDR, WR_DATA, RD_DATA;
   logic [7:0] RD_ADDR = 8'h00;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0]  ref_mem [256];
   logic [15:0] obs_q[$];
   logic [15:0] exp_q[$];
   logic [7:0]  wbuf [4];
   logic        oe_seen = 1'b0;
   logic        busy_seen = 1'b0;

   // open-drain wire: either side can pull the line low
   assign SCL_IN = scl_m;
   assign SDA_IN = sda_m & ~SDA_OE;

   always #5 CLK = ~CLK;

   i2c_target_regfile #(.SLAVE_ADDR(7'h39), .REG_ADDR_W(8)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .SCL_IN    (SCL_IN),
      .SDA_IN    (SDA_IN),
      .SDA_OE    (SDA_OE),
      .WR_STROBE (WR_STROBE),
      .WR_ADDR   (WR_ADDR),
      .WR_DATA   (WR_DATA),
      .RD_ADDR   (RD_ADDR),
      .RD_DATA   (RD_DATA),
      .BUSY      (BUSY)
   );

   always @(negedge CLK) begin
      if (WR_STROBE) obs_q.push_back({WR_ADDR, WR_DATA});
      if (SDA_OE) oe_seen = 1'b1;
      if (BUSY) busy_seen = 1'b1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic peek(input logic [7:0] a, output logic [7:0] d);
      RD_ADDR = a;
      #1;
      d = RD_DATA;
   endtask

   task automatic bus_start();
      sda_m = 1'b1; tick(Q);
      scl_m = 1'b1; tick(Q);
      sda_m = 1'b0; tick(Q);
      scl_m = 1'b0; tick(Q);
   endtask

   task automatic bus_stop();
      tick(Q);
      sda_m = 1'b0; tick(Q);
      scl_m = 1'b1; tick(Q);
      sda_m = 1'b1; tick(Q);
   endtask

   // One SCL period; returns the wired line level sampled mid-high.
   task automatic clock_bit(input logic b, output logic line);
      tick(Q);
      sda_m = b; tick(Q);
      scl_m = 1'b1; tick(Q);
      line = SDA_IN; tick(Q);
      scl_m = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack);
      logic unused;
      for (int i = 7; i >= 0; i--) clock_bit(d[i], unused);
      clock_bit(1'b1, ack);
   endtask

   task automatic recv_byte(input logic mack, output logic [7:0] d);
      logic line;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, line);
         d[i] = line;
      end
      clock_bit(mack, line);
   endtask

   // Model: bytes land at consecutive addresses, wrapping at 256.
   task automatic model_write(input logic [7:0] p, input int n);
      for (int i = 0; i < n; i++) begin
         ref_mem[(p + i) % 256] = wbuf[i];
         exp_q.push_back({8'((p + i) % 256), wbuf[i]});
      end
   endtask

   task automatic i2c_write(input string tag, input logic [7:0] p, input int n);
      logic ack;
      bus_start();
      send_byte(8'h72, ack); check({tag, " dev ack"}, ack, 0);
      send_byte(p, ack);     check({tag, " ptr ack"}, ack, 0);
      for (int i = 0; i < n; i++) begin
         send_byte(wbuf[i], ack);
         check($sformatf("%s data%0d ack", tag, i), ack, 0);
      end
      check({tag, " busy before stop"}, BUSY, 1);
      bus_stop();
      tick(4);
      check({tag, " busy after stop"}, BUSY, 0);
      model_write(p, n);
   endtask

   task automatic i2c_read(input string tag, input logic [7:0] p, input int n);
      logic       ack;
      logic [7:0] d;
      bus_start();
      send_byte(8'h72, ack); check({tag, " dev ack"}, ack, 0);
      send_byte(p, ack);     check({tag, " ptr ack"}, ack, 0);
      bus_start();
      send_byte(8'h73, ack); check({tag, " rd dev ack"}, ack, 0);
      for (int i = 0; i < n; i++) begin
         recv_byte((i == n - 1) ? 1'b1 : 1'b0, d);
         check($sformatf("%s byte%0d", tag, i), d, ref_mem[(p + i) % 256]);
      end
      tick(Q);
      check({tag, " sda released after nack"}, SDA_OE, 0);
      bus_stop();
      tick(4);
      check({tag, " busy after stop"}, BUSY, 0);
   endtask

   task automatic check_strobes(input string tag);
      check({tag, " strobe count"}, obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         check($sformatf("%s strobe%0d addr/data", tag, i), obs_q[i], exp_q[i]);
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      logic       ack, line;
      logic [7:0] d, p;
      int         n;

      for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

      // Reset state
      tick(4);
      RST = 1'b0;
      tick(2);
      check("reset sda_oe", SDA_OE, 0);
      check("reset wr_strobe", WR_STROBE, 0);
      check("reset wr_addr", WR_ADDR, 0);
      check("reset wr_data", WR_DATA, 0);
      check("reset busy", BUSY, 0);
      peek(8'h41, d); check("reset reg41", d, 0);

      // Single write
      wbuf[0] = 8'h10;
      i2c_write("single", 8'h41, 1);
      check_strobes("single");
      check("single wr_addr", WR_ADDR, 8'h41);
      check("single wr_data", WR_DATA, 8'h10);
      peek(8'h41, d); check("single reg41", d, 8'h10);

      // Burst write wrapping the pointer
      wbuf[0] = 8'hAA; wbuf[1] = 8'hBB; wbuf[2] = 8'hCC;
      i2c_write("burst", 8'hFE, 3);
      check_strobes("burst");
      peek(8'hFE, d); check("burst regFE", d, 8'hAA);
      peek(8'hFF, d); check("burst regFF", d, 8'hBB);
      peek(8'h00, d); check("burst reg00", d, 8'hCC);

      // Foreign address
      oe_seen = 1'b0; busy_seen = 1'b0;
      bus_start();
      send_byte(8'h74, ack); check("foreign addr nack", ack, 1);
      send_byte(8'h41, ack); check("foreign byte1 nack", ack, 1);
      send_byte(8'h99, ack); check("foreign byte2 nack", ack, 1);
      bus_stop();
      tick(4);
      check("foreign no sda drive", oe_seen, 0);
      check("foreign no busy", busy_seen, 0);
      check_strobes("foreign");
      for (int i = 0; i < 256; i++) begin
         peek(8'(i), d);
         check($sformatf("foreign reg%02h", i), d, ref_mem[i]);
      end

      // Read with repeated START, ACK then NACK
      wbuf[0] = 8'h20;
      i2c_write("preload", 8'h42, 1);
      check_strobes("preload");
      i2c_read("read", 8'h41, 2);
      check_strobes("read");

      // STOP in the middle of a data byte
      bus_start();
      send_byte(8'h72, ack); check("partial dev ack", ack, 0);
      send_byte(8'h20, ack); check("partial ptr ack", ack, 0);
      clock_bit(1'b1, line); clock_bit(1'b0, line);
      clock_bit(1'b1, line); clock_bit(1'b1, line);
      bus_stop();
      tick(4);
      check("partial busy", BUSY, 0);
      check_strobes("partial");
      peek(8'h20, d); check("partial reg20", d, ref_mem[8'h20]);
      wbuf[0] = 8'h5A;
      i2c_write("after partial", 8'h20, 1);
      check_strobes("after partial");
      peek(8'h20, d); check("after partial reg20", d, 8'h5A);

      // Reset while the target drives ACK
      bus_start();
      send_byte(8'h72, ack); check("rst dev ack", ack, 0);
      for (int i = 7; i >= 0; i--) clock_bit(1'(8'h33 >> i), line);
      tick(Q);
      check("rst ack driven", SDA_OE, 1);
      RST = 1'b1;
      tick(1);
      check("rst sda released", SDA_OE, 0);
      peek(8'h41, d); check("rst reg41 cleared", d, 0);
      peek(8'hFE, d); check("rst regFE cleared", d, 0);
      tick(2);
      RST = 1'b0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
      obs_q.delete(); exp_q.delete();
      oe_seen = 1'b0;
      scl_m = 1'b1; tick(Q); scl_m = 1'b0;
      for (int i = 0; i < 3; i++) clock_bit(1'b0, line);
      bus_stop();
      tick(4);
      check("rst bus ignored", oe_seen, 0);
      wbuf[0] = 8'h99;
      i2c_write("post rst", 8'h07, 1);
      check_strobes("post rst");
      peek(8'h07, d); check("post rst reg07", d, 8'h99);

      // Randomized write bursts, each read back over the bus
      for (int t = 0; t < 6; t++) begin
         p = 8'($urandom_range(0, 255));
         n = $urandom_range(1, 3);
         for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
         i2c_write($sformatf("rand%0d wr", t), p, n);
         check_strobes($sformatf("rand%0d", t));
         i2c_read($sformatf("rand%0d rd", t), p, n);
         d = 8'($urandom);
         peek(d, line == 1'b0 ? d : d);
         check($sformatf("rand%0d local rd", t), RD_DATA, ref_mem[RD_ADDR]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
